// File: rtl/byte_data_mem.sv
// byte_data_mem: byte-addressable RV32I data memory with wait-state handshake and fault flagging
module byte_data_mem #(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_valid,
  output logic [31:0]       o_rdata,
  output logic              o_fault
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] LIMIT = (ADDR_W-2)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH];
  logic we_q, we, accept, commit, bad_f3, mis, oor, fault;
  logic [2:0] f3_q, f3;
  logic [ADDR_W-1:0] addr_q, addr;
  logic [31:0] wdata_q, wdata, wsh, word, sh, ld;
  logic [ADDR_W-3:0] idx;
  logic [IW-1:0] widx;
  logic [3:0] be;
  assign o_ready = state == S_IDLE;
  assign o_valid = state == S_RESP;
  assign accept  = i_req && o_ready;
  // In IDLE the live inputs are used so a zero-wait-state access can commit on its accept edge
  assign we    = o_ready ? i_we     : we_q;
  assign f3    = o_ready ? i_funct3 : f3_q;
  assign addr  = o_ready ? i_addr   : addr_q;
  assign wdata = o_ready ? i_wdata  : wdata_q;
  // next-state logic; commit marks the edge that enters RESP
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    commit  = 1'b0;
    if (state == S_IDLE && accept) begin
      state_n = WAIT_STATES > 0 ? S_WAIT : S_RESP;
      cnt_n   = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
      commit  = WAIT_STATES == 0;
    end else if (state == S_WAIT) begin
      state_n = cnt == 4'd0 ? S_RESP : S_WAIT;
      cnt_n   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      commit  = cnt == 4'd0;
    end else if (state == S_RESP) begin
      state_n = S_IDLE;
    end
  end
  // access decode: legality, lane enables, store alignment and load extension
  always_comb begin
    idx    = addr[ADDR_W-1:2];
    widx   = idx[IW-1:0];
    bad_f3 = we ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    mis    = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    oor    = idx >= LIMIT;
    fault  = bad_f3 || mis || oor;
    be     = f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
             f3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    wsh    = wdata << {addr[1:0], 3'b000};
    word   = oor ? 32'd0 : mem[widx];
    sh     = word >> {addr[1:0], 3'b000};
    ld     = f3[1:0] == 2'b00 ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
             f3[1:0] == 2'b01 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : word;
  end
  // state register and wait counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // request fields are captured only on accept
  always_ff @(posedge i_clk) begin
    if (accept) begin
      we_q    <= i_we;
      f3_q    <= i_funct3;
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
    end
  end
  // response registers: loaded at commit, held until the next completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= 32'd0;
      o_fault <= 1'b0;
    end else if (commit) begin
      o_fault <= fault;
      o_rdata <= (fault || we) ? 32'd0 : ld;
    end
  end
  // storage: optional clear on reset, byte-lane writes on a good store commit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (CLEAR_ON_RESET != 0)
        for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (commit && we && !fault) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wsh[8*b +: 8];
    end
  end
endmodule

// File: doc/byte_data_mem.md
# byte_data_mem

Parametrised, byte-addressable data memory for the RV32I core that executes the full load/store set (LB/LH/LW/LBU/LHU/SB/SH/SW) via funct3 decode, with byte-lane write enables and sign/zero extension on loads. It uses a request/ready/valid handshake with a configurable number of wait states, so multi-cycle and pipelined cores can model slow memory. It also flags misaligned, illegal-funct3 and out-of-range accesses. It sits between the core's memory stage and the writeback mux.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words; need not be a power of two.
- ADDR_W, 32: byte-address width; word index is i_addr[ADDR_W-1:2].
- WAIT_STATES, 0: extra cycles between accept and response, 0..15.
- CLEAR_ON_RESET, 1: 1 means every word is zeroed while i_rst is high; 0 means memory is untouched by reset.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  1  request; accepted on an edge where i_req=1 and o_ready=1.
- i_we  in  1  1 = store, 0 = load; sampled at accept.
- i_funct3  in  3  RV32I load/store funct3; sampled at accept.
- i_addr  in  ADDR_W  byte address; sampled at accept.
- i_wdata  in  32  store data, LSB-justified; sampled at accept.
- o_ready  out  1  high only in IDLE.
- o_valid  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load result; registered, held until the next completion.
- o_fault  out  1  valid with o_valid: the access was rejected.

## Operation
- FSM has three states: IDLE, WAIT and RESP.
- IDLE → WAIT on accept if WAIT_STATES>0; IDLE → RESP on accept if WAIT_STATES=0.
- WAIT counts WAIT_STATES cycles using a counter loaded with WAIT_STATES-1 that decrements to 0, then moves to RESP.
- RESP lasts one cycle with o_valid=1, then returns to IDLE.
- Request fields are latched at accept. i_req while o_ready=0 is ignored; its inputs are not sampled.
- Fault conditions:
  - funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores;
  - addr[0]≠0 for halfword accesses;
  - addr[1:0]≠0 for word accesses;
  - word index ≥ DEPTH.
- A faulting access performs no write, sets o_fault=1 and o_rdata=0 in RESP, and takes the same latency as a good access.
- Stores:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected bytes of the word are preserved.
- Loads: LB/LH sign-extend the selected byte/halfword; LBU/LHU zero-extend; LW returns the whole word.
- After a good store, o_rdata = 0 and o_fault = 0.

## Timing
- Reset: when i_rst is high at an edge, the next cycle shows state=IDLE, counter=0, o_ready=1, o_valid=0, o_rdata=0, o_fault=0.
- With CLEAR_ON_RESET=1, all DEPTH words read 0 after that same edge.
- Reset overrides everything in the same edge. A transaction in WAIT or RESP is aborted, and a store whose commit edge coincides with i_rst is not written.
- If an accept occurs at edge E0, o_valid is high in the cycle after edge E0+WAIT_STATES.
- The store commit and the load capture (into o_rdata/o_fault) happen at the edge that enters RESP.
- o_ready is low from the cycle after accept through the RESP cycle.
- The minimum request spacing is WAIT_STATES+2 cycles.
- A load issued after a store's RESP cycle returns the stored data.
- Between responses, o_rdata and o_fault hold their last values.

## Test plan
- WAIT_STATES=0, reset: hold i_rst for 1 cycle, then LW at 0x0, 0x10 and (DEPTH-1)*4 → each returns 0x00000000 with o_fault=0; o_valid lands exactly 1 cycle after each accept.
- Byte-lane stores: SW 0x0=0x11223344, then SB 0x1 with wdata=0xAB, then SH 0x2 with wdata=0xCDEF → LW 0x0=0xCDEFAB44.
- Load extension on word 0x80F0FF7F at address 0x0:
  - LB 0x0 → 0x0000007F;
  - LB 0x1 → 0xFFFFFFFF;
  - LBU 0x1 → 0x000000FF;
  - LH 0x2 → 0xFFFF80F0;
  - LHU 0x2 → 0x000080F0.
- Faults: SW 0x2 with 0xDEADBEEF, then LH 0x3, funct3=011, and LW at DEPTH*4.
  - Each returns o_fault=1 and o_rdata=0.
  - A following LW 0x0 returns the previous contents unchanged.
- WAIT_STATES=3: accept at cycle 0 → o_valid at cycle 4, and o_ready=0 in cycles 1–4. i_req held high through this period is not re-accepted until cycle 5.
- Reset mid-operation: with WAIT_STATES=3, CLEAR_ON_RESET=0 and word 0x40 holding 0x0, issue SW 0x40=0x55 and assert i_rst in cycle 2.
  - No o_valid is produced and o_ready=1 in the next cycle.
  - A subsequent LW 0x40 returns 0x0.
